// File: rtl/bram_fifo_pkg.sv
// Shared types and default sizes for the BRAM-backed two-writer stream FIFO.
package bram_fifo_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } rd_state_e;
endpackage

// File: rtl/bram_fifo_arbiter_if.sv
// Stream and BRAM-port bundle; slave is the FIFO's view, master the environment's.
interface bram_fifo_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] s0_tdata;
  logic                  s0_tvalid, s0_tready;
  logic [DATA_WIDTH-1:0] s1_tdata;
  logic                  s1_tvalid, s1_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid, m_tready;
  logic                  bram_ena, bram_wea, bram_enb;
  logic [ADDR_WIDTH-1:0] bram_addra, bram_addrb;
  logic [DATA_WIDTH-1:0] bram_dina, bram_doutb;
  logic [ADDR_WIDTH:0]   fill_count;
  logic                  full, empty;

  modport slave (
    input  s0_tdata, s0_tvalid, s1_tdata, s1_tvalid, m_tready, bram_doutb,
    output s0_tready, s1_tready, m_tdata, m_tvalid,
    output bram_ena, bram_wea, bram_addra, bram_dina, bram_enb, bram_addrb,
    output fill_count, full, empty
  );

  modport master (
    output s0_tdata, s0_tvalid, s1_tdata, s1_tvalid, m_tready, bram_doutb,
    input  s0_tready, s1_tready, m_tdata, m_tvalid,
    input  bram_ena, bram_wea, bram_addra, bram_dina, bram_enb, bram_addrb,
    input  fill_count, full, empty
  );
endinterface

// File: rtl/bram_fifo_arbiter_rr.sv
// Two-way round-robin grant; the last-grant bit moves only on an accepted transfer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  // last_q = 1 means requester 1 won last, so requester 0 is favoured next
  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_d = accept ? grant[1] : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/bram_fifo_arbiter.sv
// Two arbitrated stream writers into an external 1-cycle-latency BRAM, drained
// by a three-state read FSM onto one output stream.
module bram_fifo_arbiter
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  bram_fifo_arbiter_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
  rd_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [1:0]            req, grant;
  logic                  accept, full_w, rd_issue;

  // Extra pointer bit distinguishes full from empty at equal addresses
  assign occ    = wr_ptr_q - rd_ptr_q;
  assign full_w = (occ == DEPTH);

  assign req = {bus.s1_tvalid, bus.s0_tvalid};

  rr_arbiter2 u_arb (
    .clk    (ACLK),
    .rst    (ARESET),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  assign bus.s0_tready = grant[0] & ~full_w & ~ARESET;
  assign bus.s1_tready = grant[1] & ~full_w & ~ARESET;
  assign accept = (bus.s0_tvalid & bus.s0_tready) | (bus.s1_tvalid & bus.s1_tready);

  assign bus.bram_ena   = accept;
  assign bus.bram_wea   = accept;
  assign bus.bram_addra = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.bram_dina  = grant[1] ? bus.s1_tdata : bus.s0_tdata;
  assign wr_ptr_d       = accept ? wr_ptr_q + ONE : wr_ptr_q;

  // A pop in VALID drops tvalid for the FETCH cycle, giving one word per 2 cycles
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    rd_issue   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (occ != '0) begin
          rd_issue = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        m_tdata_d  = bus.bram_doutb;
        m_tvalid_d = 1'b1;
        state_d    = VALID;
      end
      VALID: begin
        if (bus.m_tready) begin
          m_tvalid_d = 1'b0;
          if (occ != '0) begin
            rd_issue = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d  = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    if (rd_issue) rd_ptr_d = rd_ptr_q + ONE;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= EMPTY;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign bus.bram_enb   = rd_issue;
  assign bus.bram_addrb = rd_ptr_q[ADDR_WIDTH-1:0];
  assign bus.m_tdata    = m_tdata_q;
  assign bus.m_tvalid   = m_tvalid_q;
  assign bus.fill_count = occ + {{ADDR_WIDTH{1'b0}}, (state_q != EMPTY)};
  assign bus.full       = full_w;
  assign bus.empty      = (bus.fill_count == '0);
endmodule

// File: doc/bram_fifo_arbiter.md
BRAM_FIFO_ARBITER -- requirements
Module: bram_fifo_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the stream data and BRAM data.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the BRAM address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 ACLK  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 ARESET  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 s0_tdata/s0_tvalid/s0_tready  in/in/out  DATA_WIDTH/1/1  SHALL form write requester 0 (AXI-Stream subset).
REQ-006 s1_tdata/s1_tvalid/s1_tready  in/in/out  DATA_WIDTH/1/1  SHALL form write requester 1.
REQ-007 m_tdata/m_tvalid/m_tready  out/out/in  DATA_WIDTH/1/1  SHALL form the read stream.
REQ-008 bram_ena/bram_wea/bram_addra/bram_dina  out  1/1/ADDR_WIDTH/DATA_WIDTH  SHALL form the BRAM write port.
REQ-009 bram_enb/bram_addrb  out  1/ADDR_WIDTH and bram_doutb  in  DATA_WIDTH  SHALL form the BRAM read port; read latency is 1 cycle.
REQ-010 fill_count  out  ADDR_WIDTH+1  SHALL report the words held (BRAM plus read pipeline).
REQ-011 full, empty  out  1 each  SHALL flag BRAM occupancy == DEPTH and fill_count == 0, respectively.

Function
REQ-012 Write arbitration SHALL be two-way round robin: grant goes to the only valid requester; when both are valid, it goes to the requester not granted last.
REQ-013 sN_tready SHALL equal grant_N AND NOT full AND NOT ARESET; at most one tready is high per cycle.
REQ-014 The last-grant register SHALL update only on an accepted transfer (tvalid AND tready).
REQ-015 On an accepted transfer, bram_ena and bram_wea SHALL assert combinationally in that cycle, with bram_addra = wr_ptr and bram_dina = the granted tdata; wr_ptr SHALL then increment modulo DEPTH.
REQ-016 Read FSM states SHALL be EMPTY, FETCH and VALID.
REQ-017 In EMPTY, if BRAM occupancy > 0: assert bram_enb, set bram_addrb = rd_ptr, increment rd_ptr, and go to FETCH; otherwise stay in EMPTY.
REQ-018 In FETCH, register bram_doutb into m_tdata, set m_tvalid = 1, and go to VALID.
REQ-019 In VALID, m_tdata SHALL be held stable until m_tready.
REQ-020 In VALID with m_tready and occupancy > 0, issue the next read as in REQ-017 and go to FETCH.
REQ-021 In VALID with m_tready and occupancy == 0, clear m_tvalid and go to EMPTY.
REQ-022 Sustained read throughput SHALL be one word per 2 cycles; first-word latency from write to m_tvalid SHALL be 3 cycles (write at edge N, read issued at N+1, m_tvalid high after N+2).
REQ-023 BRAM occupancy SHALL be wr_ptr - rd_ptr, using ADDR_WIDTH+1-bit pointers.
REQ-024 fill_count SHALL equal occupancy + (state != EMPTY).
REQ-025 A write and a read issue in the same cycle SHALL both occur and leave occupancy unchanged.
REQ-026 A read SHALL never be issued at occupancy 0, so the same address is never written and read in one cycle.
REQ-027 When full, both tready outputs SHALL be 0; a read issue in the same cycle frees a slot for the next cycle only.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of ordering.

Reset
REQ-029 While ARESET is high: wr_ptr = rd_ptr = 0, state = EMPTY, m_tvalid = 0, m_tdata = 0, last-grant = requester 1 (so requester 0 wins first), all tready = 0, bram_ena = bram_wea = bram_enb = 0, fill_count = 0, empty = 1, full = 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored and in-flight data; BRAM contents are not cleared.

Structure
REQ-031 Package bram_fifo_pkg SHALL hold the read-FSM state enum and the default DATA_WIDTH/ADDR_WIDTH constants.
REQ-032 The round-robin grant logic SHALL be the sub-module rr_arbiter2 (inputs: req[1:0], accept, clock, reset; output: grant[1:0]).
REQ-033 A behavioural 1-cycle BRAM model SHALL be used in the bench only, never inside the block.

Verification
REQ-034 Single word: s0 writes 0x0101FFFF, m_tready = 1 -> m_tdata = 0x0101FFFF with m_tvalid 3 cycles later; fill_count returns to 0 and empty = 1.
REQ-035 Contention: s0 and s1 both valid continuously with counting data -> grants alternate 0,1,0,1 starting with s0; output order matches acceptance order.
REQ-036 Fill: m_tready = 0, write 1025 words with DEPTH = 1024 -> full = 1 and fill_count = 1025; the next write is stalled; after one pop, exactly one further write is accepted.
REQ-037 Wrap: stream 3000 words with random m_tready -> zero data mismatches and in-order delivery across pointer wrap.
REQ-038 Reset mid-stream: assert ARESET with fill_count = 7 -> all outputs take their REQ-029 values immediately; after release, first written 0xDEAD0011 is the first word read.
REQ-039 Simultaneous: steady state with occupancy 1, write and pop in the same cycle -> occupancy stays 1 and no data is lost or duplicated.
